alsu_op_sequencer: RTL and testbench

Command sequencer placed directly upstream of the ALSU. It buffers packed ALSU commands in a small FIFO and drives one command at a time onto the ALSU input pins. It holds each command stable for the ALSU's pipeline latency, then captures the ALSU's out/leds result. The result is returned on a valid/ready response channel, so a testbench or host can issue back-to-back operations without tracking ALSU timing.

---
 rtl/alsu_op_sequencer.sv | 126 ++++++++++++
 tb/tb_alsu_op_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alsu_op_sequencer.sv
// Command sequencer in front of the ALSU: buffers packed commands, holds each one on the
// ALSU pins for its pipeline latency, then returns the captured result on a valid/ready channel.
module alsu_op_sequencer #(
   parameter int DEPTH   = 4,
   parameter int LATENCY = 3
) (
   input  logic        CLK,
   input  logic        RST_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [15:0] cmd_data,
   output logic [2:0]  alsu_A,
   output logic [2:0]  alsu_B,
   output logic [2:0]  alsu_opcode,
   output logic        alsu_cin,
   output logic        alsu_serial_in,
   output logic        alsu_direction,
   output logic        alsu_red_op_A,
   output logic        alsu_red_op_B,
   output logic        alsu_bypass_A,
   output logic        alsu_bypass_B,
   input  logic [5:0]  alsu_out,
   input  logic [15:0] alsu_leds,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [5:0]  rsp_out,
   output logic        rsp_invalid,
   output logic [2:0]  rsp_opcode,
   output logic        busy,
   output logic [7:0]  done_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int WW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t          state;
   logic [15:0]     fifo_mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   logic [WW-1:0]   wait_cnt;
   logic [15:0]     hold_cmd;
   logic            push, pop;

   assign cmd_ready = (count < CW'(DEPTH));
   assign push      = cmd_valid && cmd_ready;
   assign pop       = (state == IDLE) && (count != '0);

   // Pins come straight from the held command word, so they only change at load and capture.
   assign alsu_A         = hold_cmd[2:0];
   assign alsu_B         = hold_cmd[5:3];
   assign alsu_opcode    = hold_cmd[8:6];
   assign alsu_cin       = hold_cmd[9];
   assign alsu_serial_in = hold_cmd[10];
   assign alsu_direction = hold_cmd[11];
   assign alsu_red_op_A  = hold_cmd[12];
   assign alsu_red_op_B  = hold_cmd[13];
   assign alsu_bypass_A  = hold_cmd[14];
   assign alsu_bypass_B  = hold_cmd[15];

   always_ff @(posedge CLK) begin
      if (push) fifo_mem[wr_ptr] <= cmd_data;
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_n) begin
         state       <= IDLE;
         hold_cmd    <= '0;
         wait_cnt    <= '0;
         rsp_valid   <= 1'b0;
         rsp_out     <= '0;
         rsp_invalid <= 1'b0;
         rsp_opcode  <= '0;
         busy        <= 1'b0;
         done_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pop) begin
                  hold_cmd <= fifo_mem[rd_ptr];
                  wait_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= WAIT;
               end
            end
            WAIT: begin
               // Sampling one edge after the ALSU's out register updates gives this command's result.
               if (wait_cnt == WW'(LATENCY)) begin
                  rsp_out     <= alsu_out;
                  rsp_invalid <= alsu_leds[0];
                  rsp_opcode  <= hold_cmd[8:6];
                  hold_cmd    <= '0;
                  rsp_valid   <= 1'b1;
                  state       <= RESP;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  if (done_count != 8'hFF) done_count <= done_count + 8'd1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alsu_op_sequencer.sv
// Bench for alsu_op_sequencer: a behavioural 3-stage ALSU stand-in drives alsu_out/alsu_leds,
// directed vector table plus multi-cycle sequences and a randomized scoreboard run.
module tb_alsu_op_sequencer;

   localparam int LAT = 3;

   logic        CLK = 1'b0;
   logic        RST_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [15:0] cmd_data = '0;
   logic [2:0]  alsu_A, alsu_B, alsu_opcode;
   logic        alsu_cin, alsu_serial_in, alsu_direction;
   logic        alsu_red_op_A, alsu_red_op_B, alsu_bypass_A, alsu_bypass_B;
   logic [5:0]  alsu_out;
   logic [15:0] alsu_leds;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [5:0]  rsp_out;
   logic        rsp_invalid;
   logic [2:0]  rsp_opcode;
   logic        busy;
   logic [7:0]  done_count;

   alsu_op_sequencer #(.DEPTH(4), .LATENCY(LAT)) dut (
      .CLK(CLK), .RST_n(RST_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
      .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
      .alsu_cin(alsu_cin), .alsu_serial_in(alsu_serial_in), .alsu_direction(alsu_direction),
      .alsu_red_op_A(alsu_red_op_A), .alsu_red_op_B(alsu_red_op_B),
      .alsu_bypass_A(alsu_bypass_A), .alsu_bypass_B(alsu_bypass_B),
      .alsu_out(alsu_out), .alsu_leds(alsu_leds),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_out(rsp_out),
      .rsp_invalid(rsp_invalid), .rsp_opcode(rsp_opcode),
      .busy(busy), .done_count(done_count)
   );

   always #5 CLK = ~CLK;

   // Result of one command from the ALSU's rules: {invalid, out}. Shift/rotate are not exercised.
   function automatic logic [6:0] alsu_ref(input logic [15:0] c);
      logic [2:0] a, b, op;
      int r;
      a = c[2:0]; b = c[5:3]; op = c[8:6];
      if (c[14]) return {4'b0, a};
      if (c[15]) return {4'b0, b};
      if (op >= 3'd6 || ((c[12] || c[13]) && op >= 3'd2)) return 7'b1_000000;
      case (op)
         3'd0: r = c[12] ? int'(&a) : c[13] ? int'(&b) : int'(a & b);
         3'd1: r = c[12] ? int'(^a) : c[13] ? int'(^b) : int'(a ^ b);
         3'd2: r = int'(a) + int'(b) + int'(c[9]);
         3'd3: r = int'(a) * int'(b);
         default: r = 0;
      endcase
      return {1'b0, r[5:0]};
   endfunction

   // ALSU stand-in: inputs registered at +1, result at +2, out at +3.
   wire [15:0] alsu_pk = {alsu_bypass_B, alsu_bypass_A, alsu_red_op_B, alsu_red_op_A,
                          alsu_direction, alsu_serial_in, alsu_cin, alsu_opcode, alsu_B, alsu_A};
   logic [15:0] in_r = '0;
   logic [6:0]  st_r = '0, out_r = '0;
   always @(posedge CLK) begin
      in_r  <= alsu_pk;
      st_r  <= alsu_ref(in_r);
      out_r <= st_r;
   end
   assign alsu_out  = out_r[5:0];
   assign alsu_leds = {16{out_r[6]}};

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got=%0d expected=%0d", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic do_reset();
      RST_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
      tick(); tick();
      RST_n = 1'b1;
   endtask

   function automatic logic [15:0] mk(input int a, input int b, input int op, input bit cin,
                                      input bit red_a, input bit byp_a, input bit byp_b);
      logic [15:0] c;
      c = '0;
      c[2:0] = 3'(a); c[5:3] = 3'(b); c[8:6] = 3'(op); c[9] = cin;
      c[12] = red_a; c[14] = byp_a; c[15] = byp_b;
      return c;
   endfunction

   typedef struct {
      logic [15:0] cmd;
      logic [5:0]  out;
      logic        inv;
   } vec_t;

   initial begin
      #2ms;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[5];
      logic [15:0] bp_cmd[5];
      logic [5:0]  bp_exp[5];
      logic [15:0] expq[$];
      int n, k, seen, pushed, got_n;
      bit held;
      logic [5:0] h_out; logic h_inv; logic [2:0] h_op;

      tbl[0] = '{mk(5, 3, 0, 0, 0, 0, 0), 6'd1,  1'b0};
      tbl[1] = '{16'h02BF,                 6'd15, 1'b0};
      tbl[2] = '{mk(1, 2, 6, 0, 0, 0, 0), 6'd0,  1'b1};
      tbl[3] = '{mk(3, 4, 2, 0, 1, 0, 0), 6'd0,  1'b1};
      tbl[4] = '{mk(2, 4, 0, 0, 0, 1, 1), 6'd2,  1'b0};

      bp_cmd[0] = mk(1, 2, 2, 0, 0, 0, 0); bp_exp[0] = 6'd3;
      bp_cmd[1] = mk(3, 5, 3, 0, 0, 0, 0); bp_exp[1] = 6'd15;
      bp_cmd[2] = mk(6, 3, 1, 0, 0, 0, 0); bp_exp[2] = 6'd5;
      bp_cmd[3] = mk(7, 6, 0, 0, 0, 0, 0); bp_exp[3] = 6'd6;
      bp_cmd[4] = mk(4, 4, 2, 1, 0, 0, 0); bp_exp[4] = 6'd9;

      @(negedge CLK);
      do_reset();
      check("reset_cmd_ready", cmd_ready, 1);
      check("reset_rsp_valid", rsp_valid, 0);
      check("reset_rsp_fields", {rsp_out, rsp_invalid, rsp_opcode}, 0);
      check("reset_busy", busy, 0);
      check("reset_done_count", done_count, 0);
      check("reset_alsu_pins", alsu_pk, 0);

      // Directed vectors, one at a time from IDLE
      for (int i = 0; i < 5; i++) begin
         cmd_valid = 1'b1; cmd_data = tbl[i].cmd;
         tick();
         cmd_valid = 1'b0;
         tick();
         check($sformatf("v%0d_load_pins", i), alsu_pk, tbl[i].cmd);
         check($sformatf("v%0d_busy", i), busy, 1);
         n = 1;
         while (!rsp_valid && n < 20) begin tick(); n++; end
         check($sformatf("v%0d_latency", i), n, LAT + 2);
         check($sformatf("v%0d_rsp_out", i), rsp_out, tbl[i].out);
         check($sformatf("v%0d_rsp_invalid", i), rsp_invalid, tbl[i].inv);
         check($sformatf("v%0d_rsp_opcode", i), rsp_opcode, tbl[i].cmd[8:6]);
         check($sformatf("v%0d_pins_cleared", i), alsu_pk, 0);
         tick();
         check($sformatf("v%0d_rsp_held", i), rsp_valid, 1);
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
         check($sformatf("v%0d_rsp_dropped", i), rsp_valid, 0);
         check($sformatf("v%0d_done_count", i), done_count, i + 1);
      end

      // Backpressure: one in flight plus a full FIFO, then drain in order
      do_reset();
      for (int i = 0; i < 6; i++) begin
         cmd_valid = 1'b1; cmd_data = (i < 5) ? bp_cmd[i] : 16'h0000;
         check($sformatf("bp_cmd_ready_%0d", i), cmd_ready, (i < 5) ? 1 : 0);
         tick();
      end
      cmd_valid = 1'b0;
      rsp_ready = 1'b1;
      k = 0; n = 0;
      while (k < 5 && n < 100) begin
         if (rsp_valid) begin
            check($sformatf("bp_rsp_%0d", k), rsp_out, bp_exp[k]);
            k++;
         end
         tick(); n++;
      end
      rsp_ready = 1'b0;
      check("bp_rsp_count", k, 5);
      check("bp_done_count", done_count, 5);

      // Reset while a multiply is in WAIT with another command queued behind it
      do_reset();
      cmd_valid = 1'b1; cmd_data = mk(6, 7, 3, 0, 0, 0, 0); tick();
      cmd_data = mk(1, 1, 2, 0, 0, 0, 0); tick();
      cmd_valid = 1'b0;
      tick();
      check("mr_in_wait_busy", busy, 1);
      RST_n = 1'b0; tick(); RST_n = 1'b1;
      check("mr_alsu_pins", alsu_pk, 0);
      check("mr_cmd_ready", cmd_ready, 1);
      check("mr_done_count", done_count, 0);
      check("mr_busy", busy, 0);
      rsp_ready = 1'b1; seen = 0;
      for (int i = 0; i < 12; i++) begin
         if (rsp_valid || busy) seen++;
         tick();
      end
      rsp_ready = 1'b0;
      check("mr_no_response", seen, 0);

      // Randomized traffic against the scoreboard; long enough to saturate done_count
      do_reset();
      pushed = 0; got_n = 0; n = 0; held = 0;
      while (got_n < 300 && n < 20000) begin
         if (held) begin
            check("rnd_rsp_stable", {rsp_valid, rsp_out, rsp_invalid, rsp_opcode},
                  {1'b1, h_out, h_inv, h_op});
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         if (rsp_valid) begin
            if (expq.size() == 0) begin
               check("rnd_unexpected_rsp", 1, 0);
            end else if (rsp_ready) begin
               logic [15:0] c;
               logic [6:0]  e;
               c = expq.pop_front();
               e = alsu_ref(c);
               check("rnd_rsp_out", rsp_out, e[5:0]);
               check("rnd_rsp_invalid", rsp_invalid, e[6]);
               check("rnd_rsp_opcode", rsp_opcode, c[8:6]);
               got_n++;
            end
         end
         held = rsp_valid && !rsp_ready;
         h_out = rsp_out; h_inv = rsp_invalid; h_op = rsp_opcode;
         if (pushed < 300 && $urandom_range(0, 1) == 1) begin
            logic [15:0] c;
            int ops[6];
            ops = '{0, 1, 2, 3, 6, 7};
            c = 16'($urandom);
            c[8:6] = 3'(ops[$urandom_range(0, 5)]);
            c[14] = ($urandom_range(0, 5) == 0);
            c[15] = ($urandom_range(0, 5) == 0);
            cmd_valid = 1'b1; cmd_data = c;
            if (cmd_ready) begin
               expq.push_back(c);
               pushed++;
            end
         end else begin
            cmd_valid = 1'b0;
         end
         tick(); n++;
      end
      cmd_valid = 1'b0; rsp_ready = 1'b0;
      check("rnd_all_responses", got_n, 300);
      check("rnd_done_saturated", done_count, (got_n > 255) ? 255 : got_n);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
